// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the digit-serial adder/subtractor.
//   sa_state_t : controller state (IDLE, RUN, DONE)
//   cnt_width  : width of the step counter for a given step count, never below 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // $clog2(1) is 0, which would give a zero-width counter when DIGIT == WIDTH.
  function automatic int cnt_width(input int steps);
    if (steps < 2) return 1;
    else return $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_adder_ripple_slice.sv
// ripple_slice
// Combinational DIGIT-bit ripple-carry adder built from full-adder equations.
// Ports:
//   a, b   in  DIGIT  operand digits
//   cin    in  1      carry into bit 0
//   sum    out DIGIT  sum digit
//   cout   out 1      carry out of the top bit
//   c_top  out 1      carry into the top bit (combined with cout for signed overflow)
module ripple_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[DIGIT];
  assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Multi-cycle adder/subtractor that handles DIGIT bits per clock, least
// significant digit first, with a registered carry between digits.
// WIDTH must be at least 2 and DIGIT must divide WIDTH.
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, accepted when not busy
//   sub    in  1      0: a+b+cin, 1: a-b (cin ignored)
//   a, b   in  WIDTH  operands, captured on acceptance
//   cin    in  1      carry-in, captured on acceptance
//   busy   out 1      operation in progress
//   done   out 1      one-cycle completion pulse
//   s      out WIDTH  result, held until the next completion
//   cout   out 1      final carry (in subtract mode 1 means no borrow)
//   ovf    out 1      signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  sa_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       sum_dig;
  logic                   slice_cout;
  logic                   slice_ctop;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic [WIDTH-1:0]       r_next;

  ripple_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a     (a_sh_q[DIGIT-1:0]),
    .b     (b_sh_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (sum_dig),
    .cout  (slice_cout),
    .c_top (slice_ctop)
  );

  // New digits enter at the top so that after STEPS shifts the first digit
  // sits at bit 0. The concatenation keeps this legal when DIGIT == WIDTH.
  assign r_cat  = {sum_dig, r_sh_q};
  assign r_next = r_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request too, giving back-to-back operation.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        r_sh_d  = r_next;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        // On the final digit the slice's top bit is the word's MSB.
        if (cnt_q == LAST) begin
          s_d     = r_next;
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_ctop;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
